// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings and defaults for the EX-stage forwarding / hazard controller.
// Select encoding: 00 regfile, 01 write-back, 10 MEM stage; 11 never driven.
package fwd_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 2'b00;
  localparam fwd_sel_t FWD_WB      = 2'b01;
  localparam fwd_sel_t FWD_MEM     = 2'b10;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel_unit.sv
// Operand forwarding select for one EX source register.
// Latency: purely combinational. Backpressure: none.
// Output is FWD_REGFILE when disabled or when the source is $0.
module fwd_sel_unit
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              src_en_i,
  input  logic              exmem_vld_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_vld_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  output fwd_sel_t          sel_o
);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (src_en_i && (src_i != '0)) begin
      // EX/MEM holds the younger producer, so it must win over MEM/WB
      if (exmem_vld_i && exmem_regwrite_i && (exmem_rd_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (memwb_vld_i && memwb_regwrite_i && (memwb_rd_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and flush/freeze tracking for a 5-stage pipeline.
// Latency: selects/stall combinational from tracked state; state advances each edge unless frozen.
// Backpressure: freeze holds every entry; stall_id holds ID for one cycle. FWD_HAZARD_PERF_EN adds stall_cnt.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
`ifdef FWD_HAZARD_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  input  logic              freeze,
  output fwd_sel_t          fwd_a_sel,
  output fwd_sel_t          fwd_b_sel,
  output logic              stall_id,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd
`ifdef FWD_HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              uses_rt;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } idex_t;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } wbent_t;

  idex_t  idex_q, idex_d;
  wbent_t exmem_q, memwb_q;
  logic   luh;

  assign luh = idex_q.vld && idex_q.memread && (idex_q.rd != '0) && id_valid &&
               ((idex_q.rd == id_rs) || (id_uses_rt && (idex_q.rd == id_rt)));

  // A flushed instruction is dead, so stalling on its operands would only waste a cycle
  assign stall_id = luh && !flush;

  always_comb begin
    idex_d = '0;
    if (id_valid && !flush && !stall_id) begin
      idex_d.vld      = 1'b1;
      idex_d.rs       = id_rs;
      idex_d.rt       = id_rt;
      idex_d.uses_rt  = id_uses_rt;
      idex_d.rd       = id_rd;
      idex_d.regwrite = id_regwrite;
      idex_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (!freeze) begin
      idex_q           <= idex_d;
      exmem_q.vld      <= idex_q.vld;
      exmem_q.rd       <= idex_q.rd;
      exmem_q.regwrite <= idex_q.regwrite;
      memwb_q          <= exmem_q;
    end
  end

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i            (idex_q.rs),
    .src_en_i         (idex_q.vld),
    .exmem_vld_i      (exmem_q.vld),
    .exmem_regwrite_i (exmem_q.regwrite),
    .exmem_rd_i       (exmem_q.rd),
    .memwb_vld_i      (memwb_q.vld),
    .memwb_regwrite_i (memwb_q.regwrite),
    .memwb_rd_i       (memwb_q.rd),
    .sel_o            (fwd_a_sel)
  );

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i            (idex_q.rt),
    .src_en_i         (idex_q.vld && idex_q.uses_rt),
    .exmem_vld_i      (exmem_q.vld),
    .exmem_regwrite_i (exmem_q.regwrite),
    .exmem_rd_i       (exmem_q.rd),
    .memwb_vld_i      (memwb_q.vld),
    .memwb_regwrite_i (memwb_q.regwrite),
    .memwb_rd_i       (memwb_q.rd),
    .sel_o            (fwd_b_sel)
  );

  assign wb_we = memwb_q.vld && memwb_q.regwrite;
  assign wb_rd = memwb_q.rd;

`ifdef FWD_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_id && !freeze && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: reset, forwarding distances, load-use, flush, freeze, async reset.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rt, id_regwrite, id_memread;
  logic       flush, freeze;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_id, wb_we;
  logic [4:0] wb_rd;
`ifdef FWD_HAZARD_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .freeze      (freeze),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_id    (stall_id),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd)
`ifdef FWD_HAZARD_PERF_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks are taken 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic rw, input logic mr);
    id_valid    = 1'b1;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = urt;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    id_uses_rt  = 1'b0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    freeze = 1'b0;
    nop();

    // Reset with random ID-side activity
    for (int i = 0; i < 4; i++) begin
      issue(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      flush  = 1'($urandom);
      freeze = 1'($urandom);
      tick();
    end
    settle();
    chk("rst_a", 16'(fwd_a_sel), 16'h0);
    chk("rst_b", 16'(fwd_b_sel), 16'h0);
    chk("rst_stall", 16'(stall_id), 16'h0);
    chk("rst_we", 16'(wb_we), 16'h0);
    chk("rst_rd", 16'(wb_rd), 16'h0);
`ifdef FWD_HAZARD_PERF_EN
    chk("rst_cnt", stall_cnt, 16'h0);
`endif
    flush  = 1'b0;
    freeze = 1'b0;
    nop();
    tick();
    rst_n = 1'b1;
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5
    issue(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    issue(5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0); settle();
    chk("adj_stall_id", 16'(stall_id), 16'h0);
    tick();
    nop(); settle();
    chk("adj_a", 16'(fwd_a_sel), 16'h2);
    chk("adj_b", 16'(fwd_b_sel), 16'h0);
    chk("adj_stall", 16'(stall_id), 16'h0);
    tick(); settle();
    chk("adj_wb_we", 16'(wb_we), 16'h1);
    chk("adj_wb_rd", 16'(wb_rd), 16'h3);
    drain();

    // add $3 ; nop ; or $6,$3,$3
    issue(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    nop(); tick();
    issue(5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0); tick();
    nop(); settle();
    chk("two_a", 16'(fwd_a_sel), 16'h1);
    chk("two_b", 16'(fwd_b_sel), 16'h1);
    drain();

    // add $3 ; add $3 ; and $7,$3,$0
    issue(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    issue(5'd2, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    issue(5'd3, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0); tick();
    nop(); settle();
    chk("dbl_a", 16'(fwd_a_sel), 16'h2);
    chk("dbl_b_r0", 16'(fwd_b_sel), 16'h0);
    drain();

    // lw $8 ; add $9,$8,$1
    issue(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1); tick();
    issue(5'd2, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0); settle();
    chk("lu_imm_rt", 16'(stall_id), 16'h0);
    issue(5'd8, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0); settle();
    chk("lu_stall1", 16'(stall_id), 16'h1);
    tick(); settle();
    chk("lu_stall2", 16'(stall_id), 16'h0);
    chk("lu_bub_a", 16'(fwd_a_sel), 16'h0);
    chk("lu_bub_b", 16'(fwd_b_sel), 16'h0);
    tick();
    nop(); settle();
    chk("lu_a", 16'(fwd_a_sel), 16'h1);
    chk("lu_b", 16'(fwd_b_sel), 16'h0);
`ifdef FWD_HAZARD_PERF_EN
    chk("lu_cnt", stall_cnt, 16'h1);
`endif
    drain();

    // lw $0 ; use of $0 never stalls
    issue(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); tick();
    issue(5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0); settle();
    chk("lu_r0", 16'(stall_id), 16'h0);
    drain();

    // Flush beats load-use
    issue(5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1); tick();
    issue(5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0); settle();
    chk("fl_pre", 16'(stall_id), 16'h1);
    flush = 1'b1; settle();
    chk("fl_stall", 16'(stall_id), 16'h0);
    tick();
    flush = 1'b0;
    nop(); settle();
    chk("fl_a", 16'(fwd_a_sel), 16'h0);
    chk("fl_b", 16'(fwd_b_sel), 16'h0);
    chk("fl_stall2", 16'(stall_id), 16'h0);
    drain();

    // Freeze for 3 cycles with or $6,$10,$3 waiting in ID
    issue(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    issue(5'd1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0); tick();
    issue(5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0); tick();
    issue(5'd10, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    freeze = 1'b1; settle();
    chk("fz_a0", 16'(fwd_a_sel), 16'h1);
    chk("fz_rd0", 16'(wb_rd), 16'h3);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk($sformatf("fz_a%0d", i + 1), 16'(fwd_a_sel), 16'h1);
      chk($sformatf("fz_rd%0d", i + 1), 16'(wb_rd), 16'h3);
      chk($sformatf("fz_stall%0d", i + 1), 16'(stall_id), 16'h0);
    end
    freeze = 1'b0;
    tick();
    nop(); settle();
    chk("fz_rel_a", 16'(fwd_a_sel), 16'h1);
    chk("fz_rel_b", 16'(fwd_b_sel), 16'h0);
    chk("fz_rel_we", 16'(wb_we), 16'h1);
    chk("fz_rel_rd", 16'(wb_rd), 16'ha);

    // Asynchronous reset between edges
    rst_n = 1'b0; settle();
    chk("ar_a", 16'(fwd_a_sel), 16'h0);
    chk("ar_we", 16'(wb_we), 16'h0);
    chk("ar_rd", 16'(wb_rd), 16'h0);
    chk("ar_stall", 16'(stall_id), 16'h0);
`ifdef FWD_HAZARD_PERF_EN
    chk("ar_cnt", stall_cnt, 16'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
